mem_port_arbiter: RTL

Shares the single-port synchronous data/instruction RAM between the fetch stage and the memory stage of the ARM32 pipeline. Arbitrates one access at a time and sequences the RAM read latency. Returns read data to the owning requester and drives a fetch stall when fetch is denied. Memory-stage accesses (STR/LDR issued by the memory controller via `mem_w_en`) have priority, with a starvation guard for fetch.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the fetch/memory-stage RAM port arbiter.
// Both the top level and the testbench import this package.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM
  } arb_owner_t;

  // Legal parameter ranges; the counters below are sized for the upper bounds.
  localparam int RD_LAT_MIN     = 1;
  localparam int RD_LAT_MAX     = 4;
  localparam int STARVE_MIN     = 1;
  localparam int STARVE_MAX_LIM = 15;
  localparam int LAT_W          = 2;
  localparam int STARVE_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, memory-stage and RAM-side signals around the arbiter.
// slave = arbiter side, master = requesters plus the RAM model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall_fetch;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, stall_fetch,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output ram_addr, ram_wdata, ram_we, ram_en,
    input  ram_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, stall_fetch,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_en,
    output ram_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port RAM between fetch and the memory stage: memory stage
// first, fetch forced through after STARVE_MAX denied cycles, one read in flight.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("mem_port_arbiter: RD_LAT must be in 1..4");
  end
  if (STARVE_MAX < STARVE_MIN || STARVE_MAX > STARVE_MAX_LIM) begin : g_bad_starve
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(RD_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  arb_state_t          state_reg, state_next;
  arb_owner_t          owner_reg, owner_next;
  logic [LAT_W-1:0]    lat_cnt_reg, lat_cnt_next;
  logic [STARVE_W-1:0] starve_cnt_reg, starve_cnt_next;

  logic if_win;
  logic dm_win;
  logic rd_grant;
  logic rd_done;
  logic starve_full;

  assign starve_full = (starve_cnt_reg == STARVE_TOP);

  // Grants are decided combinationally; only IDLE may grant.
  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (state_reg == IDLE) begin
      if (bus.if_req && (!bus.dm_req || starve_full)) begin
        if_win = 1'b1;
      end else if (bus.dm_req) begin
        dm_win = 1'b1;
      end
    end
  end

  assign rd_grant = if_win || (dm_win && !bus.dm_we);

  assign bus.if_gnt      = if_win;
  assign bus.dm_gnt      = dm_win;
  assign bus.stall_fetch = bus.if_req && !if_win;

  always_comb begin
    bus.ram_en    = if_win || dm_win;
    bus.ram_we    = dm_win && bus.dm_we;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (if_win) begin
      bus.ram_addr = bus.if_addr;
    end else if (dm_win) begin
      bus.ram_addr  = bus.dm_addr;
      bus.ram_wdata = bus.dm_wdata;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    lat_cnt_next    = lat_cnt_reg;
    starve_cnt_next = starve_cnt_reg;
    rd_done         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rd_grant) begin
          state_next   = RD_WAIT;
          owner_next   = if_win ? OWN_IF : OWN_DM;
          lat_cnt_next = LAT_LOAD;
        end
        if (if_win || !bus.if_req) begin
          starve_cnt_next = '0;
        end else if (!starve_full) begin
          starve_cnt_next = starve_cnt_reg + 1'b1;
        end
      end
      RD_WAIT: begin
        // ram_rdata is valid in the cycle the counter reaches zero.
        if (lat_cnt_reg == '0) begin
          rd_done    = 1'b1;
          state_next = IDLE;
          owner_next = OWN_NONE;
        end else begin
          lat_cnt_next = lat_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_NONE;
      lat_cnt_reg    <= '0;
      starve_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      lat_cnt_reg    <= lat_cnt_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Port 0 returns fetch data, port 1 returns load data.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    localparam arb_owner_t PORT_OWNER = (gi == 0) ? OWN_IF : OWN_DM;

    logic              hit;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;

    assign hit = rd_done && (owner_reg == PORT_OWNER);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rvalid_reg <= 1'b0;
        rdata_reg  <= '0;
      end else begin
        rvalid_reg <= hit;
        if (hit) begin
          rdata_reg <= bus.ram_rdata;
        end
      end
    end
  end

  assign bus.if_rvalid = g_port[0].rvalid_reg;
  assign bus.if_rdata  = g_port[0].rdata_reg;
  assign bus.dm_rvalid = g_port[1].rvalid_reg;
  assign bus.dm_rdata  = g_port[1].rdata_reg;

endmodule
